pc_controller: RTL and testbench

PC_CONTROLLER -- requirements
Module: pc_controller

---
 rtl/pc_controller_if.sv | 34 +++
 rtl/pc_controller.sv | 121 ++++++++++++
 tb/tb_pc_controller.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_controller_if.sv
// Bundle between the fetch-side hazard/branch logic and the PC controller.
// The master drives the requests; the slave (controller) drives PC control.
interface pc_controller_if #(
  parameter int CNT_W = 8
);
  logic [31:0]      PCIn;
  logic             StallReq;
  logic             BranchTaken;
  logic [31:0]      BranchTarget;
  logic             Jump;
  logic [31:0]      JumpTarget;
  logic             Halt;
  logic [31:0]      NextPC;
  logic             PCEn;
  logic             IFIDWrite;
  logic             IFIDFlush;
  logic             Halted;
  logic             AlignErr;
  logic [CNT_W-1:0] StallCount;

  modport master (
    output PCIn, StallReq, BranchTaken, BranchTarget,
    output Jump, JumpTarget, Halt,
    input  NextPC, PCEn, IFIDWrite, IFIDFlush,
    input  Halted, AlignErr, StallCount
  );

  modport slave (
    input  PCIn, StallReq, BranchTaken, BranchTarget,
    input  Jump, JumpTarget, Halt,
    output NextPC, PCEn, IFIDWrite, IFIDFlush,
    output Halted, AlignErr, StallCount
  );
endinterface

// File: rtl/pc_controller.sv
// Next-PC selection and IF/ID control: sequential fetch, stalls,
// branch/jump redirects with squash, halt, plus stall and alignment stats.
module pc_controller #(
  parameter logic [31:0] RESET_VECTOR = 32'h00000000,
  parameter int          CNT_W        = 8
) (
  input logic           Clk,
  input logic           Reset,
  pc_controller_if.slave bus
);

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    RUN   = 3'd1,
    STALL = 3'd2,
    FLUSH = 3'd3,
    HALT  = 3'd4
  } state_t;

  state_t           state;
  state_t           nxt;
  logic [31:0]      npc;
  logic [31:0]      pc_seq;
  logic [31:0]      tgt;
  logic             pcen;
  logic             wr;
  logic             fl;
  logic             redir;
  logic             aerr;
  logic [CNT_W-1:0] cnt;

  assign pc_seq = bus.PCIn + 32'd4;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= INIT;
    else       state <= nxt;
  end

  always_comb begin
    nxt   = state;
    npc   = pc_seq;
    pcen  = 1'b1;
    wr    = 1'b1;
    fl    = 1'b0;
    redir = 1'b0;
    tgt   = 32'd0;
    unique case (state)
      INIT: begin
        npc = RESET_VECTOR;
        wr  = 1'b0;
        fl  = 1'b1;
        nxt = RUN;
      end
      RUN, STALL: begin
        if (bus.Halt) begin
          npc  = bus.PCIn;
          pcen = 1'b0;
          wr   = 1'b0;
          fl   = 1'b1;
          nxt  = HALT;
        end else if (bus.BranchTaken) begin
          redir = 1'b1;
          tgt   = bus.BranchTarget;
          fl    = 1'b1;
          nxt   = FLUSH;
        end else if (bus.Jump && state == RUN) begin
          redir = 1'b1;
          tgt   = bus.JumpTarget;
          fl    = 1'b1;
          nxt   = RUN;
        end else if (bus.StallReq) begin
          npc  = bus.PCIn;
          pcen = 1'b0;
          wr   = 1'b0;
          nxt  = STALL;
        end else begin
          nxt = RUN;
        end
        if (redir) npc = {tgt[31:2], 2'b00};
      end
      // Second wrong-path slot after a branch; requests are not honoured here.
      FLUSH: begin
        fl  = 1'b1;
        nxt = RUN;
      end
      HALT: begin
        npc  = bus.PCIn;
        pcen = 1'b0;
        wr   = 1'b0;
        fl   = 1'b1;
        nxt  = HALT;
      end
      default: begin
        npc = RESET_VECTOR;
        wr  = 1'b0;
        fl  = 1'b1;
        nxt = INIT;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      aerr <= 1'b0;
      cnt  <= '0;
    end else begin
      if (redir && tgt[1:0] != 2'b00) aerr <= 1'b1;
      if ((state == RUN || state == STALL) && !pcen && cnt != '1)
        cnt <= cnt + 1'b1;
    end
  end

  assign bus.NextPC     = npc;
  assign bus.PCEn       = pcen;
  assign bus.IFIDWrite  = wr;
  assign bus.IFIDFlush  = fl;
  assign bus.Halted     = (state == HALT);
  assign bus.AlignErr   = aerr;
  assign bus.StallCount = cnt;

endmodule

// File: tb/tb_pc_controller.sv
// Directed checks of pc_controller: reset, sequential fetch, branch/jump,
// stalls, alignment flag, wrap-around, halt and reset recovery.
module tb_pc_controller;

  logic Clk;
  logic Reset;
  int   checks;
  int   errors;

  pc_controller_if #(.CNT_W(8)) bus ();

  pc_controller #(
    .RESET_VECTOR(32'h0),
    .CNT_W(8)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .bus(bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic idle();
    bus.PCIn         = 32'h0;
    bus.StallReq     = 1'b0;
    bus.BranchTaken  = 1'b0;
    bus.BranchTarget = 32'h0;
    bus.Jump         = 1'b0;
    bus.JumpTarget   = 32'h0;
    bus.Halt         = 1'b0;
  endtask

  task automatic cyc();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    idle();
    #1;
    checks++;
    if (bus.NextPC !== 32'h0 || bus.PCEn !== 1'b1 ||
        bus.IFIDWrite !== 1'b0 || bus.IFIDFlush !== 1'b1) begin
      errors++;
      $display("FAIL reset_outs got npc=%h en=%b w=%b f=%b want 0 1 0 1",
               bus.NextPC, bus.PCEn, bus.IFIDWrite, bus.IFIDFlush);
    end
    checks++;
    if (bus.Halted !== 1'b0 || bus.AlignErr !== 1'b0 ||
        bus.StallCount !== 8'd0) begin
      errors++;
      $display("FAIL reset_flags got h=%b a=%b c=%0d want 0 0 0",
               bus.Halted, bus.AlignErr, bus.StallCount);
    end
    cyc();
    Reset = 1'b0;
    #1;
    checks++;
    if (bus.NextPC !== 32'h0 || bus.IFIDFlush !== 1'b1 ||
        bus.IFIDWrite !== 1'b0) begin
      errors++;
      $display("FAIL init_cycle got npc=%h f=%b w=%b want 0 1 0",
               bus.NextPC, bus.IFIDFlush, bus.IFIDWrite);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] pc;
    pc = 32'h0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      bus.PCIn = pc;
      #1;
      checks++;
      if (bus.NextPC !== pc + 32'd4 || bus.IFIDFlush !== 1'b0 ||
          bus.PCEn !== 1'b1 || bus.IFIDWrite !== 1'b1) begin
        errors++;
        $display("FAIL seq_%0d got npc=%h f=%b want %h 0",
                 i, bus.NextPC, bus.IFIDFlush, pc + 32'd4);
      end
      pc = pc + 32'd4;
    end
  endtask

  task automatic test_branch();
    cyc();
    bus.PCIn         = 32'h40;
    bus.BranchTaken  = 1'b1;
    bus.BranchTarget = 32'h100;
    #1;
    checks++;
    if (bus.NextPC !== 32'h100 || bus.IFIDFlush !== 1'b1 ||
        bus.PCEn !== 1'b1) begin
      errors++;
      $display("FAIL br_redirect got npc=%h f=%b want 00000100 1",
               bus.NextPC, bus.IFIDFlush);
    end
    cyc();
    idle();
    bus.PCIn = 32'h100;
    #1;
    checks++;
    if (bus.NextPC !== 32'h104 || bus.IFIDFlush !== 1'b1) begin
      errors++;
      $display("FAIL br_flush got npc=%h f=%b want 00000104 1",
               bus.NextPC, bus.IFIDFlush);
    end
    cyc();
    bus.PCIn = 32'h104;
    #1;
    checks++;
    if (bus.NextPC !== 32'h108 || bus.IFIDFlush !== 1'b0) begin
      errors++;
      $display("FAIL br_resume got npc=%h f=%b want 00000108 0",
               bus.NextPC, bus.IFIDFlush);
    end
  endtask

  task automatic test_stall();
    cyc();
    bus.PCIn     = 32'h20;
    bus.StallReq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus.PCEn !== 1'b0 || bus.NextPC !== 32'h20 ||
          bus.IFIDWrite !== 1'b0 || bus.IFIDFlush !== 1'b0) begin
        errors++;
        $display("FAIL stall_%0d got en=%b npc=%h want 0 00000020",
                 i, bus.PCEn, bus.NextPC);
      end
      cyc();
    end
    bus.StallReq = 1'b0;
    #1;
    checks++;
    if (bus.NextPC !== 32'h24 || bus.PCEn !== 1'b1 ||
        bus.StallCount !== 8'd3) begin
      errors++;
      $display("FAIL stall_release got npc=%h en=%b cnt=%0d want 24 1 3",
               bus.NextPC, bus.PCEn, bus.StallCount);
    end
  endtask

  task automatic test_branch_priority();
    cyc();
    idle();
    bus.PCIn         = 32'h50;
    bus.BranchTaken  = 1'b1;
    bus.BranchTarget = 32'h300;
    bus.Jump         = 1'b1;
    bus.JumpTarget   = 32'h500;
    #1;
    checks++;
    if (bus.NextPC !== 32'h300 || bus.IFIDFlush !== 1'b1) begin
      errors++;
      $display("FAIL br_vs_jump got npc=%h want 00000300", bus.NextPC);
    end
    cyc();
    idle();
    bus.PCIn       = 32'h300;
    bus.Jump       = 1'b1;
    bus.JumpTarget = 32'h700;
    bus.StallReq   = 1'b1;
    #1;
    checks++;
    if (bus.NextPC !== 32'h304 || bus.IFIDFlush !== 1'b1 ||
        bus.PCEn !== 1'b1) begin
      errors++;
      $display("FAIL flush_ignore got npc=%h f=%b en=%b want 304 1 1",
               bus.NextPC, bus.IFIDFlush, bus.PCEn);
    end
    cyc();
    idle();
    bus.PCIn     = 32'h310;
    bus.StallReq = 1'b1;
    cyc();
    bus.BranchTaken  = 1'b1;
    bus.BranchTarget = 32'h400;
    bus.Jump         = 1'b1;
    bus.JumpTarget   = 32'h600;
    #1;
    checks++;
    if (bus.NextPC !== 32'h400 || bus.PCEn !== 1'b1 ||
        bus.IFIDFlush !== 1'b1 || bus.StallCount !== 8'd4) begin
      errors++;
      $display("FAIL br_in_stall got npc=%h en=%b f=%b cnt=%0d want 400 1 1 4",
               bus.NextPC, bus.PCEn, bus.IFIDFlush, bus.StallCount);
    end
    cyc();
    idle();
    bus.PCIn = 32'h400;
    #1;
    checks++;
    if (bus.NextPC !== 32'h404 || bus.IFIDFlush !== 1'b1) begin
      errors++;
      $display("FAIL stall_br_flush got npc=%h f=%b want 404 1",
               bus.NextPC, bus.IFIDFlush);
    end
  endtask

  task automatic test_align_wrap();
    cyc();
    idle();
    bus.PCIn       = 32'h10;
    bus.Jump       = 1'b1;
    bus.JumpTarget = 32'h203;
    #1;
    checks++;
    if (bus.NextPC !== 32'h200 || bus.IFIDFlush !== 1'b1 ||
        bus.AlignErr !== 1'b0) begin
      errors++;
      $display("FAIL jump_align got npc=%h f=%b a=%b want 200 1 0",
               bus.NextPC, bus.IFIDFlush, bus.AlignErr);
    end
    cyc();
    idle();
    bus.PCIn = 32'hFFFFFFFC;
    #1;
    checks++;
    if (bus.NextPC !== 32'h0 || bus.IFIDFlush !== 1'b0 ||
        bus.AlignErr !== 1'b1) begin
      errors++;
      $display("FAIL wrap got npc=%h f=%b a=%b want 0 0 1",
               bus.NextPC, bus.IFIDFlush, bus.AlignErr);
    end
    cyc();
    cyc();
    checks++;
    if (bus.AlignErr !== 1'b1) begin
      errors++;
      $display("FAIL align_sticky got %b want 1", bus.AlignErr);
    end
  endtask

  task automatic test_halt();
    cyc();
    idle();
    bus.PCIn = 32'h80;
    bus.Halt = 1'b1;
    #1;
    checks++;
    if (bus.PCEn !== 1'b0 || bus.IFIDWrite !== 1'b0 ||
        bus.IFIDFlush !== 1'b1) begin
      errors++;
      $display("FAIL halt_req got en=%b w=%b f=%b want 0 0 1",
               bus.PCEn, bus.IFIDWrite, bus.IFIDFlush);
    end
    cyc();
    idle();
    bus.PCIn         = 32'h80;
    bus.StallReq     = 1'b1;
    bus.BranchTaken  = 1'b1;
    bus.BranchTarget = 32'h900;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus.Halted !== 1'b1 || bus.PCEn !== 1'b0 ||
          bus.NextPC !== 32'h80) begin
        errors++;
        $display("FAIL halted_%0d got h=%b en=%b npc=%h want 1 0 80",
                 i, bus.Halted, bus.PCEn, bus.NextPC);
      end
      cyc();
    end
    #2;
    Reset = 1'b1;
    #1;
    checks++;
    if (bus.Halted !== 1'b0 || bus.NextPC !== 32'h0 || bus.PCEn !== 1'b1 ||
        bus.AlignErr !== 1'b0 || bus.StallCount !== 8'd0) begin
      errors++;
      $display("FAIL halt_reset got h=%b npc=%h en=%b a=%b c=%0d want 0 0 1 0 0",
               bus.Halted, bus.NextPC, bus.PCEn, bus.AlignErr, bus.StallCount);
    end
    @(negedge Clk);
    idle();
    Reset = 1'b0;
    #1;
    checks++;
    if (bus.NextPC !== 32'h0 || bus.IFIDFlush !== 1'b1 ||
        bus.Halted !== 1'b0) begin
      errors++;
      $display("FAIL post_halt_init got npc=%h f=%b h=%b want 0 1 0",
               bus.NextPC, bus.IFIDFlush, bus.Halted);
    end
  endtask

  task automatic test_reset_mid_stall();
    cyc();
    idle();
    bus.PCIn     = 32'h60;
    bus.StallReq = 1'b1;
    cyc();
    cyc();
    #2;
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    checks++;
    if (bus.NextPC !== 32'h0 || bus.IFIDFlush !== 1'b1 ||
        bus.PCEn !== 1'b1 || bus.StallCount !== 8'd0) begin
      errors++;
      $display("FAIL stall_reset got npc=%h f=%b en=%b c=%0d want 0 1 1 0",
               bus.NextPC, bus.IFIDFlush, bus.PCEn, bus.StallCount);
    end
    cyc();
    bus.PCIn = 32'h0;
    #1;
    checks++;
    if (bus.NextPC !== 32'h0 || bus.PCEn !== 1'b0) begin
      errors++;
      $display("FAIL stall_after_reset got npc=%h en=%b want 0 0",
               bus.NextPC, bus.PCEn);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_sequential();
    test_branch();
    test_stall();
    test_branch_priority();
    test_align_wrap();
    test_halt();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
